// File: rtl/riscv_state_pkg.sv
// Shared fetch-side types: the prefetch-queue entry and its default field widths.
package riscv_state_pkg;

    localparam int PFQ_XLEN        = 32;
    localparam int PFQ_PARCEL_SIZE = 32;

    // One parcel-queue entry: fetched data, its address and exception flags.
    typedef struct packed {
        logic [PFQ_PARCEL_SIZE-1:0] parcel;
        logic [PFQ_XLEN-1:0]        pc;
        logic                       misaligned;
        logic                       page_fault;
    } pfq_entry_t;

    // A fetch address is misaligned when it is not word aligned.
    function automatic logic adr_misaligned(input logic [1:0] adr_lsb);
        return |adr_lsb;
    endfunction

endpackage

// File: rtl/riscv_pfq_fifo.sv
// Parameterised synchronous FIFO with push/pop/flush and an occupancy count.
// Pushes while full and pops while empty are ignored; flush empties it.
module riscv_pfq_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    // Status and read port.
    always_comb begin
        empty = (cnt_q == '0);
        full  = (cnt_q == CW'(DEPTH));
        count = cnt_q;
        dout  = mem_q[rd_ptr_q];
    end

    // Next storage, pointers and count; pointers wrap modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/riscv_if_pfq.sv
// Instruction-fetch prefetch queue: issues fetch requests, tracks them in an
// in-flight FIFO, queues returned parcels and discards responses made stale
// by a flush.
// Optional feature macro: RV_PFQ_BYPASS_EN (same-cycle delivery of a response
// that arrives while the parcel queue is empty).
//
// Handshakes: a fetch is issued on a cycle where mem_req and mem_ack are both
// high (mem_req never depends on mem_ack); mem_rvalid returns one response per
// cycle in request order. A parcel leaves the head on a cycle where
// if_parcel_valid is high and if_stall is low (if_stall acts as not-ready).
module riscv_if_pfq
    import riscv_state_pkg::*;
#(
    parameter int XLEN        = PFQ_XLEN,
    parameter int PARCEL_SIZE = PFQ_PARCEL_SIZE,
    parameter int DEPTH       = 4
) (
    input  logic                     rstn,
    input  logic                     clk,
    input  logic [XLEN-1:0]          if_nxt_pc,
    input  logic                     if_stall,
    input  logic                     if_flush,
    output logic                     if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0]   if_parcel,
    output logic [XLEN-1:0]          if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
    output logic                     if_parcel_misaligned,
    output logic                     if_parcel_page_fault,
    output logic                     mem_req,
    output logic [XLEN-1:0]          mem_adr,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [PARCEL_SIZE-1:0]   mem_rdata,
    input  logic                     mem_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;
    localparam int IW = XLEN + 1;

    logic [IW-1:0] inf_din, inf_dout;
    logic [CW-1:0] inf_count, pq_count;
    logic          inf_empty, pq_empty;
    pfq_entry_t    pq_din, pq_dout, head;
    logic [CW-1:0] discard_q, discard_d;
    logic [SW-1:0] credit_used;
    logic          issue, resp_stale, resp_live;
    logic          pq_push, pq_pop, head_valid;

    // Request side: credits cover queued, in-flight and still-to-discard fetches.
    always_comb begin
        credit_used     = SW'(inf_count) + SW'(pq_count) + SW'(discard_q);
        mem_req         = rstn & ~if_flush & (credit_used < SW'(DEPTH));
        mem_adr         = if_nxt_pc;
        issue           = mem_req & mem_ack;
        if_stall_nxt_pc = ~issue;
        inf_din         = {if_nxt_pc, adr_misaligned(if_nxt_pc[1:0])};
    end

    // Response classification and the entry built from it.
    always_comb begin
        resp_stale        = mem_rvalid & (discard_q != '0);
        resp_live         = mem_rvalid & (discard_q == '0) & ~inf_empty;
        pq_din            = '0;
        pq_din.parcel     = mem_rdata;
        pq_din.pc         = inf_dout[IW-1:1];
        pq_din.misaligned = inf_dout[0];
        pq_din.page_fault = mem_err;
    end

    // Discard counter: a flush moves every in-flight fetch into it.
    always_comb begin
        discard_d = discard_q;
        if (if_flush) begin
            discard_d = discard_q + inf_count - CW'(resp_stale | resp_live);
        end else if (resp_stale) begin
            discard_d = discard_q - CW'(1);
        end
    end

    // Head selection, queue push and pop.
    always_comb begin
`ifdef RV_PFQ_BYPASS_EN
        head_valid = ~pq_empty | (resp_live & ~if_flush);
        head       = pq_empty ? pq_din : pq_dout;
        pq_pop     = ~pq_empty & ~if_stall & ~if_flush;
        pq_push    = resp_live & ~if_flush & ~(pq_empty & ~if_stall);
`else
        head_valid = ~pq_empty;
        head       = pq_dout;
        pq_pop     = head_valid & ~if_stall & ~if_flush;
        pq_push    = resp_live & ~if_flush;
`endif
    end

    // Outputs are zero whenever the head is not valid.
    always_comb begin
        if_parcel_valid      = {(PARCEL_SIZE/16){head_valid}};
        if_parcel            = head_valid ? head.parcel : '0;
        if_parcel_pc         = head_valid ? head.pc : '0;
        if_parcel_misaligned = head_valid & head.misaligned;
        if_parcel_page_fault = head_valid & head.page_fault;
    end

    // Discard counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) discard_q <= '0;
        else       discard_q <= discard_d;
    end

    riscv_pfq_fifo #(.W(IW), .DEPTH(DEPTH)) u_inflight (
        .clk   (clk),
        .rstn  (rstn),
        .push  (issue),
        .pop   (resp_live),
        .flush (if_flush),
        .din   (inf_din),
        .dout  (inf_dout),
        .count (inf_count),
        .empty (inf_empty)
    );

    riscv_pfq_fifo #(.W($bits(pfq_entry_t)), .DEPTH(DEPTH)) u_parcel_q (
        .clk   (clk),
        .rstn  (rstn),
        .push  (pq_push),
        .pop   (pq_pop),
        .flush (if_flush),
        .din   (pq_din),
        .dout  (pq_dout),
        .count (pq_count),
        .empty (pq_empty)
    );

endmodule

// File: tb/tb_riscv_if_pfq.sv
// Directed bench for riscv_if_pfq: a one-cycle-latency memory responder and
// an ordered scoreboard of expected parcel addresses.
module tb_riscv_if_pfq;

    localparam logic [31:0] KEY  = 32'h5A5A_0000;
    localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_nxt_pc;
    logic        if_stall, if_flush;
    logic        if_stall_nxt_pc;
    logic [31:0] if_parcel, if_parcel_pc;
    logic [1:0]  if_parcel_valid;
    logic        if_parcel_misaligned, if_parcel_page_fault;
    logic        mem_req, mem_ack, mem_rvalid, mem_err;
    logic [31:0] mem_adr, mem_rdata;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];
    logic        hold, spurious, auto_inc;
    logic [31:0] err_adr;
    logic        got;

    // Clock.
    always #5 clk = ~clk;

    riscv_if_pfq dut (
        .rstn                 (rstn),
        .clk                  (clk),
        .if_nxt_pc            (if_nxt_pc),
        .if_stall             (if_stall),
        .if_flush             (if_flush),
        .if_stall_nxt_pc      (if_stall_nxt_pc),
        .if_parcel            (if_parcel),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_parcel_page_fault (if_parcel_page_fault),
        .mem_req              (mem_req),
        .mem_adr              (mem_adr),
        .mem_ack              (mem_ack),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .mem_err              (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the parcel leaving the head against the oldest expected fetch.
    task automatic sb_check();
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected_parcel_pc", 64'(if_parcel_pc), NONE);
        end else begin
            e = exp_q.pop_front();
            chk("sb_pc", 64'(if_parcel_pc), 64'(e));
            chk("sb_parcel", 64'(if_parcel), 64'(e ^ KEY));
            chk("sb_misaligned", 64'(if_parcel_misaligned), 64'(|e[1:0]));
            chk("sb_page_fault", 64'(if_parcel_page_fault), 64'(e == err_adr));
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic mis, input logic pf);
        chk({tag, "_valid"}, 64'(if_parcel_valid), 64'(2'b11));
        chk({tag, "_pc"}, 64'(if_parcel_pc), 64'(pc));
        chk({tag, "_parcel"}, 64'(if_parcel), 64'(pc ^ KEY));
        chk({tag, "_mis"}, 64'(if_parcel_misaligned), 64'(mis));
        chk({tag, "_pf"}, 64'(if_parcel_page_fault), 64'(pf));
    endtask

    // One clock: sample handshakes, pass the edge, then the responder drives
    // the response for whatever was accepted one cycle earlier.
    task automatic tick();
        logic        acc;
        logic [31:0] a, r;
        #1;
        acc = rstn && mem_req && mem_ack;
        a   = mem_adr;
        if (if_flush) exp_q.delete();
        else if (if_parcel_valid[0] && !if_stall) sb_check();
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
            pend.push_back(a);
            exp_q.push_back(a);
            n_acc++;
            if (auto_inc) if_nxt_pc = a + 32'd4;
        end
        if (!hold && pend.size() > 0) begin
            r          = pend.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = r ^ KEY;
            mem_err    = (r == err_adr);
        end else if (spurious) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0BAD_0BAD;
            mem_err    = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            mem_err    = 1'b0;
        end
        #1;
    endtask

    initial begin
        rstn = 1'b0; if_nxt_pc = '0; if_stall = 1'b0; if_flush = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        hold = 1'b0; spurious = 1'b0; auto_inc = 1'b0; err_adr = 32'hFFFF_FFF0;

        // Reset state.
        @(negedge clk); @(negedge clk); #1;
        if_nxt_pc = 32'h0000_0123; mem_ack = 1'b1; #1;
        chk("rst_valid", 64'(if_parcel_valid), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_parcel", 64'(if_parcel), 64'(0));
        chk("rst_pc", 64'(if_parcel_pc), 64'(0));
        chk("rst_flags", 64'({if_parcel_misaligned, if_parcel_page_fault}), 64'(0));
        mem_ack = 1'b0;
        @(negedge clk); rstn = 1'b1; #1;

        // In-order stream 0x200/0x204/0x208, one parcel per cycle.
        if_nxt_pc = 32'h200; mem_ack = 1'b1; auto_inc = 1'b1; #1;
        chk("s1_mem_req", 64'(mem_req), 64'(1));
        chk("s1_mem_adr", 64'(mem_adr), 64'(32'h200));
        chk("s1_stall_nxt", 64'(if_stall_nxt_pc), 64'(0));
        tick();
        chk("s1_latency_valid", 64'(if_parcel_valid), 64'(0));
        tick();
        chk_head("s1_h0", 32'h200, 1'b0, 1'b0);
        tick();
        mem_ack = 1'b0; #1;
        chk_head("s1_h1", 32'h204, 1'b0, 1'b0);
        chk("s1_stall_nxt_idle", 64'(if_stall_nxt_pc), 64'(1));
        tick();
        chk_head("s1_h2", 32'h208, 1'b0, 1'b0);
        tick();
        chk("s1_drained", 64'(if_parcel_valid), 64'(0));

        // Stall six cycles: only DEPTH fetches may be issued.
        if_stall = 1'b1; if_nxt_pc = 32'h300; mem_ack = 1'b1; n_acc = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("s2_issued", 64'(n_acc), 64'(4));
        chk("s2_mem_req", 64'(mem_req), 64'(0));
        chk("s2_stall_nxt", 64'(if_stall_nxt_pc), 64'(1));
        mem_ack = 1'b0; auto_inc = 1'b0; if_stall = 1'b0; #1;
        chk_head("s2_h0", 32'h300, 1'b0, 1'b0);
        tick(); chk_head("s2_h1", 32'h304, 1'b0, 1'b0);
        tick(); chk_head("s2_h2", 32'h308, 1'b0, 1'b0);
        tick(); chk_head("s2_h3", 32'h30C, 1'b0, 1'b0);
        tick(); chk("s2_drained", 64'(if_parcel_valid), 64'(0));

        // Flush with three fetches in flight, restart at 0x400.
        hold = 1'b1; if_nxt_pc = 32'h500; mem_ack = 1'b1; auto_inc = 1'b1;
        tick(); tick(); tick();
        auto_inc = 1'b0; if_flush = 1'b1; if_nxt_pc = 32'h400; #1;
        chk("s3_flush_mem_req", 64'(mem_req), 64'(0));
        chk("s3_flush_stall_nxt", 64'(if_stall_nxt_pc), 64'(1));
        tick();
        if_flush = 1'b0; hold = 1'b0; #1;
        chk("s3_mem_req_after", 64'(mem_req), 64'(1));
        tick();
        mem_ack = 1'b0; #1;
        chk("s3_credit_full", 64'(mem_req), 64'(0));
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (if_parcel_valid[0]) got = 1'b1;
        end
        chk("s3_got_parcel", 64'(got), 64'(1));
        chk_head("s3_first", 32'h400, 1'b0, 1'b0);
        tick();
        chk("s3_drained", 64'(if_parcel_valid), 64'(0));

        // Bus error flags only its own entry; misaligned fetch address.
        err_adr = 32'h210; if_stall = 1'b1; if_nxt_pc = 32'h20C; mem_ack = 1'b1; auto_inc = 1'b1;
        tick(); tick(); tick();
        mem_ack = 1'b0; auto_inc = 1'b0;
        tick(); tick();
        if_stall = 1'b0; #1;
        chk_head("s4_h0", 32'h20C, 1'b0, 1'b0);
        tick(); chk_head("s4_h1", 32'h210, 1'b0, 1'b1);
        tick(); chk_head("s4_h2", 32'h214, 1'b0, 1'b0);
        tick(); chk("s4_drained", 64'(if_parcel_valid), 64'(0));
        err_adr = 32'hFFFF_FFF0;
        if_nxt_pc = 32'h202; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk_head("s4_misaligned", 32'h202, 1'b1, 1'b0);
        tick();

        // Second flush while two stale responses are still owed.
        hold = 1'b1; if_nxt_pc = 32'h600; mem_ack = 1'b1; auto_inc = 1'b1;
        tick(); tick();
        mem_ack = 1'b0; if_flush = 1'b1; #1;
        chk("s5_flush1_mem_req", 64'(mem_req), 64'(0));
        tick();
        if_flush = 1'b0; mem_ack = 1'b1; #1;
        chk("s5_mem_req_disc2", 64'(mem_req), 64'(1));
        tick();
        mem_ack = 1'b0; auto_inc = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0; hold = 1'b0; if_nxt_pc = 32'h700; mem_ack = 1'b1; #1;
        chk("s5_mem_req_disc3", 64'(mem_req), 64'(1));
        tick();
        mem_ack = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (if_parcel_valid[0]) got = 1'b1;
        end
        chk("s5_got_parcel", 64'(got), 64'(1));
        chk_head("s5_first", 32'h700, 1'b0, 1'b0);
        tick();
        chk("s5_drained", 64'(if_parcel_valid), 64'(0));

        // Response with nothing in flight is ignored; then empty-queue arrival.
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        tick();
        chk("s6_spurious_valid", 64'(if_parcel_valid), 64'(0));
        chk("s6_spurious_credit", 64'(mem_req), 64'(1));
        if_stall = 1'b1; if_nxt_pc = 32'h800; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; #1;
`ifdef RV_PFQ_BYPASS_EN
        chk_head("s6_bypass", 32'h800, 1'b0, 1'b0);
`else
        chk("s6_no_bypass", 64'(if_parcel_valid), 64'(0));
`endif
        tick();
        chk_head("s6_stored", 32'h800, 1'b0, 1'b0);
        if_stall = 1'b0;
        tick();
        chk("s6_drained", 64'(if_parcel_valid), 64'(0));

        // Reset in the middle of traffic drops everything outstanding.
        if_stall = 1'b1; if_nxt_pc = 32'h900; mem_ack = 1'b1; auto_inc = 1'b1;
        tick(); tick(); tick();
        rstn = 1'b0; mem_ack = 1'b0; auto_inc = 1'b0; mem_rvalid = 1'b0;
        pend.delete(); exp_q.delete(); #1;
        chk("s7_rst_valid", 64'(if_parcel_valid), 64'(0));
        chk("s7_rst_mem_req", 64'(mem_req), 64'(0));
        chk("s7_rst_pc", 64'(if_parcel_pc), 64'(0));
        tick();
        rstn = 1'b1; #1;
        chk("s7_credit_free", 64'(mem_req), 64'(1));
        if_nxt_pc = 32'hA00; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk_head("s7_after_rst", 32'hA00, 1'b0, 1'b0);
        if_stall = 1'b0;
        tick();
        chk("s7_drained", 64'(if_parcel_valid), 64'(0));
        chk("sb_leftover", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_if_pfq.md
RISCV_IF_PFQ -- requirements
Module: riscv_if_pfq

Interface
REQ-001 Parameter XLEN, default 32; address and PC width.
REQ-002 Parameter PARCEL_SIZE, default 32; fetched parcel width.
REQ-003 Parameter DEPTH, default 4, power of two, >=2; capacity of the parcel queue and the maximum number of requests in flight.
REQ-004 Port: rstn  in  1  asynchronous active-low reset.
REQ-005 Port: clk  in  1  single clock, all state on rising edge.
REQ-006 Port: if_nxt_pc  in  XLEN  address to fetch next.
REQ-007 Port: if_stall  in  1  fetch stage cannot accept a parcel this cycle.
REQ-008 Port: if_flush  in  1  discard queue and all in-flight fetches.
REQ-009 Port: if_stall_nxt_pc  out  1  high when if_nxt_pc was not accepted this cycle.
REQ-010 Port: if_parcel / if_parcel_pc  out  PARCEL_SIZE / XLEN  head parcel and its address.
REQ-011 Port: if_parcel_valid  out  PARCEL_SIZE/16  all bits equal, high when the head entry is valid.
REQ-012 Port: if_parcel_misaligned, if_parcel_page_fault  out  1 each  head entry exception flags.
REQ-013 Port: mem_req  out  1; mem_adr  out  XLEN; mem_ack  in  1  request accepted.
REQ-014 Port: mem_rvalid  in  1; mem_rdata  in  PARCEL_SIZE; mem_err  in  1  in-order response, error flag.

Function
REQ-015 mem_req SHALL be high when if_flush is low and (in-flight + queued) < DEPTH; mem_adr SHALL equal if_nxt_pc combinationally.
REQ-016 Request is issued when mem_req & mem_ack; if_stall_nxt_pc SHALL be ~(mem_req & mem_ack).
REQ-017 Each issued request SHALL push {mem_adr, |mem_adr[1:0]} into an in-flight FIFO of DEPTH entries.
REQ-018 Each mem_rvalid SHALL pop the in-flight FIFO; the unit SHALL never assert mem_rvalid handling with the FIFO empty (response with nothing in flight is ignored).
REQ-019 Non-stale response SHALL push {mem_rdata, pc, misaligned, mem_err} into the parcel queue in the same edge; latency mem_rvalid to if_parcel_valid = 1 cycle.
REQ-020 Head SHALL pop when if_parcel_valid & ~if_stall & ~if_flush.
REQ-021 Push and pop in the same cycle SHALL keep the count unchanged; pointers wrap modulo DEPTH.
REQ-022 On if_flush the parcel queue SHALL empty and a discard counter SHALL load the in-flight count minus any response accepted that cycle; subsequent responses SHALL decrement it and be dropped until zero.
REQ-023 Flush while discard counter is non-zero SHALL add newly in-flight requests to it; no request is issued in a flush cycle.
REQ-024 Credit check (REQ-015) SHALL count discard-pending requests as in-flight.
REQ-025 mem_err SHALL set if_parcel_page_fault for that entry only; if_parcel_misaligned SHALL be set when address bits [1:0] != 0; parcels are still delivered.

Reset
REQ-026 While rstn low: queue and in-flight FIFO empty, discard counter 0, if_parcel_valid 0, mem_req 0, flags 0, if_parcel 0, if_parcel_pc 0.
REQ-027 Reset mid-operation SHALL drop all outstanding responses; bus is expected to be reset together.

Configuration
REQ-028 Macro RV_PFQ_BYPASS_EN: when defined, a non-stale response arriving with queue empty SHALL appear on if_parcel* combinationally that cycle and, if consumed, not be stored; when undefined, latency is strictly 1 cycle (REQ-019).

Structure
REQ-029 Shared package riscv_state_pkg SHALL hold the pfq entry struct typedef (parcel, pc, misaligned, page_fault).
REQ-030 One sub-module riscv_pfq_fifo (parameterised sync FIFO, push/pop/flush/count) SHALL be instantiated for both the in-flight FIFO and the parcel queue.

Verification
REQ-031 Fetch 0x200,0x204,0x208, mem_ack=1, rvalid 1 cycle later -> parcels out in order, if_parcel_pc 0x200/0x204/0x208, one per cycle.
REQ-032 if_stall held 6 cycles, DEPTH=4 -> exactly 4 requests issued, then mem_req=0, if_stall_nxt_pc=1; release -> 4 parcels drained without loss.
REQ-033 3 requests in flight, if_flush, if_nxt_pc=0x400 -> 3 responses dropped, first delivered parcel has pc 0x400.
REQ-034 Response with mem_err=1 at 0x210 -> that entry page_fault=1, neighbours 0; fetch at 0x202 -> misaligned=1.
REQ-035 Second flush while discard counter=2 -> no stale parcel delivered; with RV_PFQ_BYPASS_EN, empty-queue response visible same cycle.
